// File: rtl/base_pkg.sv
// -----------------------------------------------------------------------------
// base_pkg
// Shared types and constants for the base library.
//   state_t     : occupancy state of the two-entry skid buffer (EMPTY/HALF/FULL)
//   STALL_CNT_W : width of the optional saturating stall counter in base_skid
// -----------------------------------------------------------------------------
package base_pkg;

    // Occupancy of base_skid: EMPTY = no word, HALF = word in main,
    // FULL = words in main and skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/base_vlat.sv
// -----------------------------------------------------------------------------
// base_vlat
// Plain enabled register with asynchronous active-high reset to a
// per-instance reset value. Building block for the base library stages.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset; loads rstv
//   i_en  : load enable; register holds when low
//   i_d   : next value
//   o_q   : registered value
// Parameters: width (bits), rstv (reset value).
// -----------------------------------------------------------------------------
module base_vlat #(
    parameter int unsigned       width = 1,
    parameter logic [width-1:0]  rstv  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [width-1:0] i_d,
    output logic [width-1:0] o_q
);

    logic [width-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= rstv;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/base_skid.sv
// -----------------------------------------------------------------------------
// base_skid
// Two-entry elastic pipeline stage with valid/ready handshakes on both sides.
// Upstream ready is a flop, so no combinational path exists from o_r to i_r.
// Words leave in strict FIFO order from the main register; the skid register
// absorbs the one extra word accepted while downstream back-pressure is
// still invisible to the producer.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high reset
//   i_v       : upstream valid
//   i_r       : upstream ready (registered)
//   i_d       : upstream data [width-1:0]
//   o_v       : downstream valid
//   o_r       : downstream ready
//   o_d       : downstream data [width-1:0], driven by the main register
//   stall_cnt : saturating count of cycles with o_v=1 and o_r=0
//               (present only when BASE_SKID_STALL_CNT_EN is defined)
//
// Parameters: width (data bits), rstv (reset value of main and skid).
// Build option: define BASE_SKID_STALL_CNT_EN to add the stall counter.
// -----------------------------------------------------------------------------
module base_skid
    import base_pkg::*;
#(
    parameter int unsigned      width = 8,
    parameter logic [width-1:0] rstv  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_v,
    output logic                   i_r,
    input  logic [width-1:0]       i_d,
    output logic                   o_v,
    input  logic                   o_r,
    output logic [width-1:0]       o_d
`ifdef BASE_SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Registered storage
    // -------------------------------------------------------------------------
    logic [1:0]       r_state_raw;
    state_t           r_state;
    logic             r_ir;
    logic [width-1:0] r_main;
    logic [width-1:0] r_skid;

    state_t           w_state_d;
    logic             w_ir_d;
    logic             w_acc;
    logic             w_main_en;
    logic             w_main_sel_skid;
    logic [width-1:0] w_main_d;
    logic             w_skid_en;

    assign r_state = state_t'(r_state_raw);

    // State register (process 1 of the FSM).
    base_vlat #(
        .width (2),
        .rstv  (EMPTY)
    ) u_state (
        .clk   (clk),
        .reset (reset),
        .i_en  (1'b1),
        .i_d   (w_state_d),
        .o_q   (r_state_raw)
    );

    // Ready resets low and rises on the first edge after reset release.
    base_vlat #(
        .width (1),
        .rstv  (1'b0)
    ) u_ir (
        .clk   (clk),
        .reset (reset),
        .i_en  (1'b1),
        .i_d   (w_ir_d),
        .o_q   (r_ir)
    );

    base_vlat #(
        .width (width),
        .rstv  (rstv)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_main_en),
        .i_d   (w_main_d),
        .o_q   (r_main)
    );

    base_vlat #(
        .width (width),
        .rstv  (rstv)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_skid_en),
        .i_d   (i_d),
        .o_q   (r_skid)
    );

    // -------------------------------------------------------------------------
    // Next-state and data-enable logic (process 2 of the FSM)
    // -------------------------------------------------------------------------
    assign w_acc = i_v & r_ir;

    always_comb begin
        w_state_d       = r_state;
        w_main_en       = 1'b0;
        w_main_sel_skid = 1'b0;
        w_skid_en       = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_main_en = 1'b1;
                    w_state_d = HALF;
                end
            end
            HALF: begin
                if (w_acc) begin
                    if (o_r) begin
                        // Pass-through: drain and refill main in one edge.
                        w_main_en = 1'b1;
                    end else begin
                        // Producer could not yet see the stall; park the word.
                        w_skid_en = 1'b1;
                        w_state_d = FULL;
                    end
                end else if (o_r) begin
                    w_state_d = EMPTY;
                end
            end
            FULL: begin
                // i_r is low here, so no upstream word can arrive.
                if (o_r) begin
                    w_main_en       = 1'b1;
                    w_main_sel_skid = 1'b1;
                    w_state_d       = HALF;
                end
            end
            default: begin
                w_state_d = EMPTY;
            end
        endcase
    end

    assign w_main_d = w_main_sel_skid ? r_skid : i_d;

    // Ready is computed from the next state so it falls on the very edge that
    // fills skid and rises on the edge that drains it.
    assign w_ir_d = (w_state_d != FULL);

    // -------------------------------------------------------------------------
    // Outputs (process 3 of the FSM)
    // -------------------------------------------------------------------------
    always_comb begin
        o_v = (r_state != EMPTY);
        i_r = r_ir;
        o_d = r_main;
    end

`ifdef BASE_SKID_STALL_CNT_EN
    // -------------------------------------------------------------------------
    // Stall counter: cycles where a word is offered but not taken.
    // -------------------------------------------------------------------------
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (o_v && !o_r && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_base_skid.sv
module tb_base_skid;

    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] RSTV = 8'hA5;

    logic             clk;
    logic             reset;
    logic             i_v;
    logic             i_r;
    logic [WIDTH-1:0] i_d;
    logic             o_v;
    logic             o_r;
    logic [WIDTH-1:0] o_d;
`ifdef BASE_SKID_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    base_skid #(
        .width (WIDTH),
        .rstv  (RSTV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_v       (i_v),
        .i_r       (i_r),
        .i_d       (i_d),
        .o_v       (o_v),
        .o_r       (o_r),
        .o_d       (o_d)
`ifdef BASE_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two words, a registered ready,
    // the last word shown on o_d, and a saturating stall count.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ir;
    logic [WIDTH-1:0] m_od;
    int unsigned      m_cnt;
    bit               m_acc;

    task automatic model_reset();
        m_q.delete();
        m_ir  = 1'b0;
        m_od  = RSTV;
        m_cnt = 0;
        m_acc = 1'b0;
    endtask

    // Advance one clock edge, update the model from the inputs the DUT saw,
    // then compare all outputs shortly after the edge.
    task automatic tick();
        bit drn;
        @(posedge clk);
        m_acc = i_v && m_ir;
        drn   = (m_q.size() != 0) && o_r;
        if ((m_q.size() != 0) && !o_r && (m_cnt < 32'hFFFF)) m_cnt++;
        if (drn) void'(m_q.pop_front());
        if (m_acc) m_q.push_back(i_d);
        m_ir = (m_q.size() < 2);
        if (m_q.size() != 0) m_od = m_q[0];
        #1;
        check_eq("o_v", o_v, (m_q.size() != 0));
        check_eq("i_r", i_r, m_ir);
        check_eq("o_d", o_d, m_od);
`ifdef BASE_SKID_STALL_CNT_EN
        check_eq("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    initial begin
        reset = 1'b1;
        i_v   = 1'b0;
        i_d   = '0;
        o_r   = 1'b0;
        model_reset();

        // Reset state and ready rising one edge after release.
        #12;
        check_eq("rst_o_v", o_v, 0);
        check_eq("rst_i_r", i_r, 0);
        check_eq("rst_o_d", o_d, RSTV);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_eq("rel_i_r", i_r, 1);

        // Streaming 01..10 with o_r=1.
        o_r = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            i_v = 1'b1;
            i_d = WIDTH'(k);
            tick();
            check_eq("stream_o_d", o_d, k);
            check_eq("stream_i_r", i_r, 1);
        end
        i_v = 1'b0;
        tick();
        check_eq("stream_end_o_v", o_v, 0);

        // Back-pressure: two words with o_r=0.
        o_r = 1'b0;
        i_v = 1'b1;
        i_d = 8'h01;
        tick();
        check_eq("bp_first_i_r", i_r, 1);
        i_d = 8'h02;
        tick();
        check_eq("bp_full_i_r", i_r, 0);
        check_eq("bp_hold_o_d", o_d, 8'h01);
        i_v = 1'b0;
        tick();
        check_eq("bp_still_o_d", o_d, 8'h01);
        o_r = 1'b1;
        tick();
        check_eq("bp_drain_o_d", o_d, 8'h02);
        check_eq("bp_drain_i_r", i_r, 1);
        tick();
        check_eq("bp_empty_o_v", o_v, 0);

        // Bubble: one word, o_v high exactly one cycle, o_d stays stale.
        i_v = 1'b1;
        i_d = 8'h3C;
        tick();
        check_eq("bub_o_v", o_v, 1);
        check_eq("bub_o_d", o_d, 8'h3C);
        i_v = 1'b0;
        tick();
        check_eq("bub_end_o_v", o_v, 0);
        check_eq("bub_stale_o_d", o_d, 8'h3C);

        // Random traffic; upstream holds its word until accepted.
        i_v = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            o_r = 1'($urandom % 2);
            if (!(i_v && !m_acc) || c == 0) begin
                i_v = 1'($urandom % 2);
                i_d = WIDTH'($urandom);
            end
            tick();
        end

        // Reset mid-operation: fill, then assert reset between edges.
        o_r = 1'b0;
        i_v = 1'b1;
        i_d = 8'h77;
        tick();
        i_d = 8'h88;
        tick();
        i_v = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("midrst_o_v", o_v, 0);
        check_eq("midrst_i_r", i_r, 0);
        check_eq("midrst_o_d", o_d, RSTV);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_eq("midrst_rel_i_r", i_r, 1);

`ifdef BASE_SKID_STALL_CNT_EN
        // Long stall saturates the counter; reset clears it.
        o_r = 1'b0;
        i_v = 1'b1;
        i_d = 8'h5A;
        tick();
        i_v = 1'b0;
        for (int c = 0; c < 70000; c++) tick();
        check_eq("stall_sat", stall_cnt, 16'hFFFF);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("stall_rst", stall_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
